spike_event_arbiter: RTL and testbench

SPIKE_EVENT_ARBITER -- requirements
Module: spike_event_arbiter

---
 rtl/spike_event_arbiter.sv | 105 ++++++++++
 tb/tb_spike_event_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_arbiter.sv
// Captures timestamped spikes from NUM_SRC neurons into per-source slots and
// issues them one at a time through a valid/ready output register, round-robin.
module spike_event_arbiter #(
  parameter  int NUM_SRC = 4,
  parameter  int TS_W    = 8,
  localparam int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] spike_in,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [TS_W-1:0]    evt_time,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow,
  output logic [7:0]         drop_count,
  input  logic               clear_ovf
);

  logic [TS_W-1:0]    ts;
  logic [TS_W-1:0]    ts_reg [NUM_SRC];
  logic [ID_W-1:0]    rr_ptr;

  logic               hit_hi, hit_lo, found, load;
  logic [ID_W-1:0]    sel_hi, sel_lo, sel, rr_next;
  logic [NUM_SRC-1:0] load_mask, capture, drop;
  logic [8:0]         drop_num, drop_sum;
  logic [7:0]         drop_base;

  // Round-robin pick: lowest pending index at or above rr_ptr, else the
  // lowest pending index below it (the wrapped part of the search).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    sel_hi = '0;
    sel_lo = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        if (i >= int'(rr_ptr)) begin
          hit_hi = 1'b1;
          sel_hi = ID_W'(i);
        end else begin
          hit_lo = 1'b1;
          sel_lo = ID_W'(i);
        end
      end
    end
    found   = hit_hi | hit_lo;
    sel     = hit_hi ? sel_hi : sel_lo;
    rr_next = (sel == ID_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
  end

  // A source being loaded this cycle frees its slot, so a spike on it re-captures.
  always_comb begin
    load      = found && (!evt_valid || evt_ready);
    load_mask = load ? (NUM_SRC'(1) << sel) : '0;
    capture   = enable ? (spike_in & (~pending | load_mask)) : '0;
    drop      = enable ? (spike_in & pending & ~load_mask) : '0;
    drop_num  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_num = drop_num + 9'(drop[i]);
    end
    drop_base = clear_ovf ? 8'd0 : drop_count;
    drop_sum  = {1'b0, drop_base} + drop_num;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    if (reset) begin
      ts         <= '0;
      pending    <= '0;
      overflow   <= '0;
      drop_count <= '0;
      rr_ptr     <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_time   <= '0;
      // NOTE: the timestamp slots are reset too; they are a handful of
      // flops, not a RAM, and a stale slot must never reach evt_time.
      for (int i = 0; i < NUM_SRC; i++) ts_reg[i] <= '0;
    end else begin
      if (enable) ts <= ts + 1'b1;
      pending <= (pending & ~load_mask) | capture;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (capture[i]) ts_reg[i] <= ts;
      end
      overflow   <= (clear_ovf ? '0 : overflow) | drop;
      drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      if (load) begin
        evt_valid <= 1'b1;
        evt_id    <= sel;
        evt_time  <= ts_reg[sel];
        rr_ptr    <= rr_next;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Directed bench for spike_event_arbiter: a vector table for single and burst
// spikes, then hand-written sequences for stall, drop, collision, wrap and reset.
module tb_spike_event_arbiter;

  logic       clk = 1'b0;
  logic       reset, enable, evt_ready, clear_ovf;
  logic [3:0] spike_in;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [7:0] evt_time;
  logic [3:0] pending, overflow;
  logic [7:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  spike_event_arbiter #(.NUM_SRC(4), .TS_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .spike_in  (spike_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_time  (evt_time),
    .pending   (pending),
    .overflow  (overflow),
    .drop_count(drop_count),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [3:0] spike;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [7:0] exp_time;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [3:0] spike, input logic ready,
                     input logic ev, input logic [1:0] id, input logic [7:0] tm,
                     input logic [3:0] pend);
    vec_t v;
    v.rst = rst; v.spike = spike; v.ready = ready;
    v.exp_valid = ev; v.exp_id = id; v.exp_time = tm; v.exp_pend = pend;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; spike_in = '0; clear_ovf = 1'b0; enable = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Single spike at ts=5, then two full bursts after a reset.
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
    add(0, 4'b0001, 1, 0, 0, 0,  4'b0001);
    add(0, 4'b0000, 1, 1, 0, 5,  4'b0000);
    add(0, 4'b0000, 1, 0, 0, 0,  4'b0000);
    add(1, 4'b0000, 1, 0, 0, 0,  4'b0000);
    add(0, 4'b1111, 1, 0, 0, 0,  4'b1111);
    add(0, 4'b0000, 1, 1, 0, 0,  4'b1110);
    add(0, 4'b0000, 1, 1, 1, 0,  4'b1100);
    add(0, 4'b0000, 1, 1, 2, 0,  4'b1000);
    add(0, 4'b0000, 1, 1, 3, 0,  4'b0000);
    add(0, 4'b1111, 1, 0, 0, 0,  4'b1111);
    add(0, 4'b0000, 1, 1, 0, 5,  4'b1110);
    add(0, 4'b0000, 1, 1, 1, 5,  4'b1100);
    add(0, 4'b0000, 1, 1, 2, 5,  4'b1000);
    add(0, 4'b0000, 1, 1, 3, 5,  4'b0000);
    add(0, 4'b0000, 1, 0, 0, 0,  4'b0000);

    reset = 1'b1; enable = 1'b1; spike_in = '0; evt_ready = 1'b1; clear_ovf = 1'b0;
    tick();
    reset = 1'b0;
    check("reset valid",    32'(evt_valid),  32'd0);
    check("reset id",       32'(evt_id),     32'd0);
    check("reset time",     32'(evt_time),   32'd0);
    check("reset pending",  32'(pending),    32'd0);
    check("reset overflow", 32'(overflow),   32'd0);
    check("reset drops",    32'(drop_count), 32'd0);

    foreach (vq[i]) begin
      reset = vq[i].rst; spike_in = vq[i].spike; evt_ready = vq[i].ready;
      tick();
      check($sformatf("vec%0d valid", i),   32'(evt_valid), 32'(vq[i].exp_valid));
      check($sformatf("vec%0d pending", i), 32'(pending),   32'(vq[i].exp_pend));
      if (vq[i].exp_valid) begin
        check($sformatf("vec%0d id", i),   32'(evt_id),   32'(vq[i].exp_id));
        check($sformatf("vec%0d time", i), 32'(evt_time), 32'(vq[i].exp_time));
      end
    end
    reset = 1'b0;

    // Backpressure: id 1 held while stalled, then id 1 accepted and id 2 issued.
    do_reset();
    evt_ready = 1'b0;
    spike_in = 4'b0010; tick();
    spike_in = 4'b0100; tick();
    spike_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d valid", i), 32'(evt_valid), 32'd1);
      check($sformatf("stall%0d id", i),    32'(evt_id),    32'd1);
      check($sformatf("stall%0d time", i),  32'(evt_time),  32'd0);
    end
    evt_ready = 1'b1; tick();
    check("bp second id",   32'(evt_id),    32'd2);
    check("bp second time", 32'(evt_time),  32'd1);
    tick();
    check("bp drained",     32'(evt_valid), 32'd0);

    // Drops, clear, clear-vs-drop, multi-source drop, saturation.
    do_reset();
    evt_ready = 1'b0;
    spike_in = 4'b1000; tick();
    spike_in = 4'b0000; tick();
    check("drop held id", 32'(evt_id), 32'd3);
    spike_in = 4'b0001; tick();
    check("drop first capture", 32'(pending),    32'b0001);
    check("drop first no drop", 32'(drop_count), 32'd0);
    tick();
    check("drop overflow", 32'(overflow),   32'b0001);
    check("drop count",    32'(drop_count), 32'd1);
    spike_in = 4'b0000; clear_ovf = 1'b1; tick();
    check("clear overflow", 32'(overflow),   32'd0);
    check("clear count",    32'(drop_count), 32'd0);
    spike_in = 4'b0001; tick();
    check("clear+drop overflow", 32'(overflow),   32'b0001);
    check("clear+drop count",    32'(drop_count), 32'd1);
    clear_ovf = 1'b0;
    spike_in = 4'b1110; tick();
    check("capture under held id", 32'(pending),    32'b1111);
    check("no drop on held id",    32'(drop_count), 32'd1);
    spike_in = 4'b0111; tick();
    check("multi drop overflow", 32'(overflow),   32'b0111);
    check("multi drop count",    32'(drop_count), 32'd4);
    spike_in = 4'b0001;
    for (int i = 0; i < 300; i++) tick();
    check("drop saturate",   32'(drop_count), 32'd255);
    check("held id stable",  32'(evt_id),     32'd3);
    check("held valid",      32'(evt_valid),  32'd1);

    // Collision: source 2 re-spikes in the cycle its event is loaded.
    do_reset();
    evt_ready = 1'b1;
    spike_in = 4'b0100; tick();
    tick();
    check("coll valid",    32'(evt_valid),  32'd1);
    check("coll id",       32'(evt_id),     32'd2);
    check("coll time",     32'(evt_time),   32'd0);
    check("coll pending",  32'(pending),    32'b0100);
    check("coll no drop",  32'(drop_count), 32'd0);
    spike_in = 4'b0000; tick();
    check("coll next id",   32'(evt_id),   32'd2);
    check("coll next time", 32'(evt_time), 32'd1);

    // Timestamp wrap, enable freeze, then reset with an event outstanding.
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    spike_in = 4'b0001; tick();
    spike_in = 4'b0010; tick();
    check("wrap id0 time", 32'(evt_time), 32'd255);
    spike_in = 4'b0000; tick();
    check("wrap id1",      32'(evt_id),   32'd1);
    check("wrap id1 time", 32'(evt_time), 32'd0);
    enable = 1'b0; spike_in = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    check("freeze pending",  32'(pending),    32'd0);
    check("freeze overflow", 32'(overflow),   32'd0);
    check("freeze valid",    32'(evt_valid),  32'd0);
    enable = 1'b1; spike_in = 4'b0001; tick();
    spike_in = 4'b0000; tick();
    check("freeze ts held", 32'(evt_time), 32'd2);
    evt_ready = 1'b0; spike_in = 4'b0011; tick();
    evt_ready = 1'b1; spike_in = 4'b0000; tick();
    evt_ready = 1'b0; tick();
    check("rr id after 0",    32'(evt_id),    32'd1);
    check("pre-reset valid",  32'(evt_valid), 32'd1);
    check("pre-reset pending", 32'(pending),  32'b0001);
    reset = 1'b1; tick();
    check("mid reset valid",   32'(evt_valid), 32'd0);
    check("mid reset id",      32'(evt_id),    32'd0);
    check("mid reset time",    32'(evt_time),  32'd0);
    check("mid reset pending", 32'(pending),   32'd0);
    reset = 1'b0; evt_ready = 1'b1; tick();
    check("post reset valid",   32'(evt_valid), 32'd0);
    check("post reset pending", 32'(pending),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
